u32_to_ascii: RTL
=================

// Module: u32_to_ascii
// PURPOSE
//   Converts a 32-bit binary value into a stream of ASCII digit characters, most significant first.
//   Sits directly upstream of the iterative shift-subtract divider:
//     - sends it dividend/divisor pairs;
//     - consumes its quotient/remainder;
//     - pushes remainder digits onto a small stack, then replays them MSB-first to a character sink
//       (text console / UART TX).
// PARAMETERS
//   RADIX   10  output number base, legal 2..16; digits >= 10 emitted as 'A'..'F'
//   DEPTH   10  digit stack depth; must be >= digits of 0xFFFFFFFF in RADIX (32 for RADIX=2)
// PORTS
//   clk        in   1   single clock, all logic on posedge
//   rst_n      in   1   synchronous reset, active low
//   in_valid   in   1   in_value offered
//   in_ready   out  1   block idle, accepts in_value
//   in_value   in   32  number to convert
//   div_start  out  1   one-cycle pulse: divider latches div_a/div_b
//   div_a      out  32  dividend
//   div_b      out  32  divisor, constant RADIX
//   div_done   in   1   one-cycle pulse: div_quot/div_rem valid this cycle
//   div_quot   in   32  quotient
//   div_rem    in   32  remainder (< RADIX)
//   out_valid  out  1   out_char valid
//   out_ready  in   1   sink accepts out_char
//   out_char   out  8   ASCII character
//   out_last   out  1   out_char is final character of this number
// BEHAVIOUR
//   Reset (rst_n=0 at posedge), output values:
//     - in_ready=0 during reset, 1 on first cycle after;
//     - out_valid=0, out_last=0, out_char=0, div_start=0, div_a=0, div_b=RADIX;
//     - stack count=0, state=IDLE.
//   Reset mid-operation:
//     - discards stack and value;
//     - any later div_done from an in-flight division is ignored.
//   States:
//     - IDLE: in_ready=1. On in_valid&in_ready latch value, go START.
//     - START: div_start=1 for exactly one cycle, div_a=value; go WAIT.
//     - WAIT: hold until div_done. On div_done:
//         - push digit char = rem<10 ? 8'h30+rem : 8'h37+rem;
//         - if div_quot==0 go EMIT, else value<=div_quot and go START.
//     - EMIT: out_valid=1, out_char=stack top, out_last=(count==1).
//         - On out_valid&out_ready: pop.
//         - After popping the last char go IDLE (in_ready=1 next cycle).
//   Handshake rules:
//     - out_char/out_last stable while out_valid&!out_ready;
//     - in_ready=0 in every state but IDLE;
//     - div_done outside WAIT is ignored.
//   Leading zeros: never emitted. Value 0 still performs one division and emits the single char '0'.
//   Latency: per digit = divider latency + 2 cycles; first char out_valid one cycle after the final div_done.
//   Stack overflow: impossible for legal DEPTH. If count==DEPTH on push, the digit is dropped; no wrap.
//   Widths:
//     - div_rem: only [3:0] used;
//     - digit arithmetic is 8-bit;
//     - stack pointer is $clog2(DEPTH+1) bits.
// CONFIGURATION
//   U2A_SIGNED_EN defined:
//     - in_value is two's complement;
//     - if bit31=1, the block divides the magnitude (-in_value, 32-bit unsigned);
//     - EMIT is preceded by one extra character '-' (8'h2D), with out_last=0.
//     - 0x80000000 -> magnitude 2147483648.
//   U2A_SIGNED_EN undefined:
//     - in_value is unsigned;
//     - no sign logic, no '-' state.
// TESTING
//   Bench pairs this block with the 33-tick divider model (done pulse on tick 33) and a random-stall sink.
//   1) in_value=1234, out_ready=1 -> chars 31,32,33,34; out_last on 34; 4 div_start pulses.
//   2) in_value=0 -> single char 30 with out_last=1; exactly 1 div_start.
//   3) in_value=0xFFFFFFFF (unsigned) -> "4294967295", 10 chars, 10 divisions.
//   4) in_value=1234, out_ready toggling 1 of 3 cycles -> same 4 chars, out_char stable while stalled, no drop/dup.
//   5) U2A_SIGNED_EN, in_value=0x80000000 -> "-2147483648"; in_value=0xFFFFFFFF -> "-1".
//   6) rst_n low 1 cycle during WAIT, late div_done after reset -> no push, out_valid=0, in_ready=1; next value 7 -> "7".

Source files
------------

// File: rtl/u32_to_ascii.sv
// u32_to_ascii: converts a 32-bit value to MSB-first ASCII digits via an external divider; define U2A_SIGNED_EN for signed input
module u32_to_ascii #(
  parameter int RADIX = 10,
  parameter int DEPTH = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_done,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_char,
  output logic        out_last
);
  localparam int PW = $clog2(DEPTH + 1);
`ifdef U2A_SIGNED_EN
  typedef enum logic [2:0] {IDLE, START, WAIT, SIGN, EMIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, WAIT, EMIT} state_t;
`endif
  state_t state, next;
  logic [31:0] value;
  logic [PW-1:0] cnt;
  logic [7:0] stk [0:(1<<PW)-1];
  logic [3:0] rem;
  logic [7:0] digit, top;
  logic push, pop, unused_rem;
  assign rem = div_rem[3:0];
  assign unused_rem = ^div_rem[31:4];
  assign digit = rem < 4'd10 ? 8'h30 + {4'h0, rem} : 8'h37 + {4'h0, rem};
  assign top = stk[cnt - PW'(1)];
  assign push = state == WAIT && div_done;
  assign pop = state == EMIT && out_ready;
  assign div_a = value;
  assign div_b = 32'(RADIX);
`ifdef U2A_SIGNED_EN
  logic neg;
  logic [31:0] mag;
  assign mag = in_value[31] ? -in_value : in_value;
`endif
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= next;
  end
  // next-state and handshake outputs
  always_comb begin
    next = state;
    in_ready = 1'b0;
    div_start = 1'b0;
    out_valid = 1'b0;
    out_char = 8'h00;
    out_last = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) next = START;
      end
      START: begin
        div_start = 1'b1;
        next = WAIT;
      end
`ifdef U2A_SIGNED_EN
      WAIT: if (div_done) next = div_quot != 0 ? START : neg ? SIGN : EMIT;
      SIGN: begin
        out_valid = 1'b1;
        out_char = 8'h2D;
        if (out_ready) next = EMIT;
      end
`else
      WAIT: if (div_done) next = div_quot != 0 ? START : EMIT;
`endif
      EMIT: begin
        out_valid = 1'b1;
        out_char = top;
        out_last = cnt == PW'(1);
        if (out_ready && cnt <= PW'(1)) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end
  // working value and digit stack; a full stack drops further digits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
      cnt <= '0;
`ifdef U2A_SIGNED_EN
      neg <= 1'b0;
`endif
    end else begin
      if (state == IDLE && in_valid) begin
`ifdef U2A_SIGNED_EN
        value <= mag;
        neg <= in_value[31];
`else
        value <= in_value;
`endif
      end
      if (push) begin
        if (div_quot != 0) value <= div_quot;
        if (cnt != PW'(DEPTH)) begin
          stk[cnt] <= digit;
          cnt <= cnt + PW'(1);
        end
      end
      if (pop && cnt != '0) cnt <= cnt - PW'(1);
    end
  end
endmodule
